// File: rtl/if_id_buffer_if.sv
// IF/ID boundary bundle: fetch-side offer/accept and decode-side head/stall signals.
interface if_id_buffer_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] InstrF;
    logic [XLEN-1:0] PCF;
    logic [XLEN-1:0] PCPlus4F;
    logic            ValidF;
    logic            ReadyF;
    logic            StallD;
    logic [XLEN-1:0] InstrD;
    logic [XLEN-1:0] PCD;
    logic [XLEN-1:0] PCPlus4D;
    logic            ValidD;

    modport master (
        output InstrF, PCF, PCPlus4F, ValidF, StallD,
        input  ReadyF, InstrD, PCD, PCPlus4D, ValidD
    );

    modport slave (
        input  InstrF, PCF, PCPlus4F, ValidF, StallD,
        output ReadyF, InstrD, PCD, PCPlus4D, ValidD
    );
endinterface

// File: rtl/if_id_buffer.sv
// Two-entry FIFO between fetch and decode; flushed by a taken branch/jump,
// with a saturating count of discarded wrong-path instructions.
module if_id_buffer #(
    parameter int              XLEN = 32,
    parameter logic [XLEN-1:0] NOP  = XLEN'(32'h00000013)
) (
    input  logic         clk,
    input  logic         rst,
    if_id_buffer_if.slave bus,
    input  logic         FlushD,
    output logic [15:0]  DropCnt
);
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
    } entry_t;

    localparam entry_t EMPTY = entry_t'({NOP, {(2*XLEN){1'b0}}});

    entry_t      slot_reg  [2];
    entry_t      slot_next [2];
    logic [1:0]  count_reg, count_next;
    logic [15:0] drop_cnt_reg, drop_cnt_next;

    logic        ready, valid, push, pop;
    entry_t      incoming;
    logic [16:0] drop_sum;

    // Ready/valid come from state only so flush and stall never reach fetch combinationally.
    assign ready    = (count_reg != 2'd2);
    assign valid    = (count_reg != 2'd0);
    assign push     = bus.ValidF & ready & ~FlushD;
    assign pop      = valid & ~bus.StallD & ~FlushD;
    assign incoming = '{instr: bus.InstrF, pc: bus.PCF, pc4: bus.PCPlus4F};

    // Everything held plus an instruction fetch is handing over this edge is lost.
    assign drop_sum = {1'b0, drop_cnt_reg} + 17'(count_reg) + 17'(bus.ValidF & ready);

    always_comb begin
        count_next    = count_reg;
        drop_cnt_next = drop_cnt_reg;
        for (int i = 0; i < 2; i++) begin
            slot_next[i] = slot_reg[i];
        end

        if (FlushD) begin
            count_next    = 2'd0;
            drop_cnt_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            for (int i = 0; i < 2; i++) begin
                slot_next[i] = EMPTY;
            end
        end else if (push && pop) begin
            // Only reachable with one entry held: the head leaves and the newcomer takes its place.
            slot_next[0] = incoming;
        end else if (push) begin
            slot_next[count_reg[0]] = incoming;
            count_next              = count_reg + 2'd1;
        end else if (pop) begin
            slot_next[0] = slot_reg[1];
            slot_next[1] = EMPTY;
            count_next   = count_reg - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg    <= 2'd0;
            drop_cnt_reg <= 16'd0;
            for (int i = 0; i < 2; i++) begin
                slot_reg[i] <= EMPTY;
            end
        end else begin
            count_reg    <= count_next;
            drop_cnt_reg <= drop_cnt_next;
            for (int i = 0; i < 2; i++) begin
                slot_reg[i] <= slot_next[i];
            end
        end
    end

    assign bus.ReadyF   = ready;
    assign bus.ValidD   = valid;
    assign bus.InstrD   = valid ? slot_reg[0].instr : NOP;
    assign bus.PCD      = valid ? slot_reg[0].pc    : '0;
    assign bus.PCPlus4D = valid ? slot_reg[0].pc4   : '0;
    assign DropCnt      = drop_cnt_reg;
endmodule
